decode_stage_pipe: RTL and testbench

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decstage_pkg.sv | 26 ++
 rtl/rf_bypass.sv | 53 +++++
 rtl/decode_stage_pipe.sv | 132 +++++++++++++
 tb/tb_decode_stage_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/decstage_pkg.sv
// Shared encodings for the decode stage: immediate modes, instruction field
// positions and default datapath sizing.
package decstage_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RD_MSB  = 20;
  localparam int RD_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IMM_SEXT      = 2'b00,
    IMM_ZEXT      = 2'b01,
    IMM_HI16      = 2'b10,
    IMM_SEXT_SHL2 = 2'b11
  } imm_sel_e;

endpackage

// File: rtl/rf_bypass.sv
// Register file with two combinational read ports, write-through bypass and
// a hard-wired zero register.
module rf_bypass #(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write landing on the address being read this cycle is forwarded.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (wr_live && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (wr_live && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register read, immediate extension, load-use hazard
// detection and the one-cycle decode/execute pipeline register.
module decode_stage_pipe
  import decstage_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              In_valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [1:0]        Imm_sel,
  input  logic              RF_B_sel,
  input  logic              Is_load,
  input  logic              WB_WrEn,
  input  logic [ADDR_W-1:0] WB_Addr,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  input  logic              RF_WrData_sel,
  output logic              Out_valid,
  output logic [DATA_W-1:0] Immed,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [ADDR_W-1:0] Dst_addr,
  output logic              Load_use_stall
);

  function automatic logic signed [DATA_W-1:0] imm_extend(
    input logic [15:0] imm,
    input logic [1:0]  sel
  );
    logic signed [DATA_W-1:0] sext;
    logic signed [DATA_W-1:0] res;
    sext = DATA_W'($signed(imm));
    case (imm_sel_e'(sel))
      IMM_SEXT: res = sext;
      IMM_ZEXT: res = DATA_W'(imm);
      IMM_HI16: res = DATA_W'({imm, 16'b0});
      default:  res = sext <<< 2;
    endcase
    return res;
  endfunction

  logic [ADDR_W-1:0]        rs_addr_p0;
  logic [ADDR_W-1:0]        rd_addr_p0;
  logic [ADDR_W-1:0]        rt_addr_p0;
  logic [ADDR_W-1:0]        b_addr_p0;
  logic [DATA_W-1:0]        wb_data_p0;
  logic [DATA_W-1:0]        rf_a_p0;
  logic [DATA_W-1:0]        rf_b_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic                     hazard_p0;

  logic                     vld_p1;
  logic                     ld_p1;
  logic [ADDR_W-1:0]        dst_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        rf_a_p1;
  logic [DATA_W-1:0]        rf_b_p1;

  // Only the register fields and imm16 feed the datapath.
  logic unused_instr;
  assign unused_instr = ^Instr;

  // ---- p0: decode (combinational) ----
  assign rs_addr_p0 = Instr[RS_LSB +: ADDR_W];
  assign rd_addr_p0 = Instr[RD_LSB +: ADDR_W];
  assign rt_addr_p0 = Instr[RT_LSB +: ADDR_W];
  assign b_addr_p0  = RF_B_sel ? rd_addr_p0 : rt_addr_p0;
  assign wb_data_p0 = RF_WrData_sel ? MEM_out : ALU_out;
  assign imm_p0     = imm_extend(Instr[IMM_MSB:IMM_LSB], Imm_sel);

  rf_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk       (Clk),
    .rst_n     (Reset),
    .wr_en     (WB_WrEn),
    .wr_addr   (WB_Addr),
    .wr_data   (wb_data_p0),
    .rd_addr_a (rs_addr_p0),
    .rd_addr_b (b_addr_p0),
    .rd_data_a (rf_a_p0),
    .rd_data_b (rf_b_p0)
  );

  assign hazard_p0 = vld_p1 && ld_p1 && (dst_p1 != '0) && In_valid &&
                     ((dst_p1 == rs_addr_p0) || (dst_p1 == b_addr_p0));

  // ---- p1: decode/execute pipeline register ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_p1  <= 1'b0;
      ld_p1   <= 1'b0;
      dst_p1  <= '0;
      imm_p1  <= '0;
      rf_a_p1 <= '0;
      rf_b_p1 <= '0;
    end else if (Flush) begin
      vld_p1  <= 1'b0;
      ld_p1   <= 1'b0;
      dst_p1  <= '0;
      imm_p1  <= '0;
      rf_a_p1 <= '0;
      rf_b_p1 <= '0;
    end else if (Stall) begin
      vld_p1  <= vld_p1;
    end else if (hazard_p0) begin
      vld_p1  <= 1'b0;
    end else begin
      vld_p1  <= In_valid;
      ld_p1   <= Is_load;
      dst_p1  <= rd_addr_p0;
      imm_p1  <= imm_p0;
      rf_a_p1 <= rf_a_p0;
      rf_b_p1 <= rf_b_p0;
    end
  end

  assign Out_valid      = vld_p1;
  assign Immed          = imm_p1;
  assign RF_A           = rf_a_p1;
  assign RF_B           = rf_b_p1;
  assign Dst_addr       = dst_p1;
  assign Load_use_stall = hazard_p0;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios followed by random traffic,
// all compared against a behavioural model of registers and pipeline outputs.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid, stall, flush, rf_b_sel, is_load;
  logic [1:0]  imm_sel;
  logic        wb_wren, wrdata_sel;
  logic [4:0]  wb_addr;
  logic [31:0] alu_out, mem_out;
  logic        out_valid, load_use_stall;
  logic [31:0] immed, rf_a, rf_b;
  logic [4:0]  dst_addr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic        e_vld, e_ld;
  logic [4:0]  e_dst;
  logic [31:0] e_imm, e_a, e_b;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(32), .NUM_REGS(32)) dut (
    .Clk            (clk),
    .Reset          (rst_n),
    .Instr          (instr),
    .In_valid       (in_valid),
    .Stall          (stall),
    .Flush          (flush),
    .Imm_sel        (imm_sel),
    .RF_B_sel       (rf_b_sel),
    .Is_load        (is_load),
    .WB_WrEn        (wb_wren),
    .WB_Addr        (wb_addr),
    .ALU_out        (alu_out),
    .MEM_out        (mem_out),
    .RF_WrData_sel  (wrdata_sel),
    .Out_valid      (out_valid),
    .Immed          (immed),
    .RF_A           (rf_a),
    .RF_B           (rf_b),
    .Dst_addr       (dst_addr),
    .Load_use_stall (load_use_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [1:0] sel);
    int s;
    s = imm[15] ? int'(imm) - 65536 : int'(imm);
    case (sel)
      2'd0:    return 32'(s);
      2'd1:    return {16'h0000, imm};
      2'd2:    return 32'(int'(imm) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  function automatic logic [31:0] mk(input int rs, input int rd, input logic [15:0] imm);
    return {6'h23, 5'(rs), 5'(rd), imm};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    e_vld = 0; e_ld = 0; e_dst = '0; e_imm = '0; e_a = '0; e_b = '0;
  endtask

  task automatic idle();
    instr = '0; in_valid = 0; stall = 0; flush = 0; rf_b_sel = 0; is_load = 0;
    imm_sel = 2'd0; wb_wren = 0; wrdata_sel = 0; wb_addr = '0; alu_out = '0; mem_out = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/vld"}, 64'(out_valid), 64'(e_vld));
    check({tag, "/imm"}, 64'(immed), 64'(e_imm));
    check({tag, "/a"},   64'(rf_a), 64'(e_a));
    check({tag, "/b"},   64'(rf_b), 64'(e_b));
    check({tag, "/dst"}, 64'(dst_addr), 64'(e_dst));
  endtask

  // One clock: check the hazard request, advance the model across the edge,
  // then check the registered outputs.
  task automatic cycle(input string tag);
    logic [4:0] rs, ba;
    logic       hz;
    logic [31:0] wd;
    rs = instr[25:21];
    ba = rf_b_sel ? instr[20:16] : instr[15:11];
    hz = e_vld && e_ld && (e_dst != 0) && in_valid && (e_dst == rs || e_dst == ba);
    #1;
    check({tag, "/lus"}, 64'(load_use_stall), 64'(hz));
    @(posedge clk);
    wd = wrdata_sel ? mem_out : alu_out;
    if (wb_wren && wb_addr != 0) m_rf[wb_addr] = wd;
    if (flush) begin
      e_vld = 0; e_ld = 0; e_dst = '0; e_imm = '0; e_a = '0; e_b = '0;
    end else if (stall) begin
      e_vld = e_vld;
    end else if (hz) begin
      e_vld = 0;
    end else begin
      e_vld = in_valid;
      e_ld  = is_load;
      e_dst = instr[20:16];
      e_imm = ref_imm(instr[15:0], imm_sel);
      e_a   = m_rf[rs];
      e_b   = m_rf[ba];
    end
    #1;
    check_outputs(tag);
  endtask

  logic [31:0] imm_tab [4];

  initial begin
    imm_tab[0] = 32'hFFFF8001;
    imm_tab[1] = 32'h00008001;
    imm_tab[2] = 32'h80010000;
    imm_tab[3] = 32'hFFFE0004;

    idle();
    model_clear();
    rst_n = 0;
    #2;
    check_outputs("reset");
    check("reset/lus", 64'(load_use_stall), 64'd0);
    @(negedge clk);
    rst_n = 1;
    cycle("idle");

    // Write register 3, read it back through rs
    wb_wren = 1; wb_addr = 5'd3; wrdata_sel = 0; alu_out = 32'd10; mem_out = 32'd99;
    cycle("wr3");
    idle(); instr = mk(3, 9, 16'h0000); in_valid = 1;
    cycle("rd3");
    check("rd3/a_const", 64'(rf_a), 64'd10);
    check("rd3/vld_const", 64'(out_valid), 64'd1);

    // Same-cycle write-through on the B port (rt = 5)
    idle(); wb_wren = 1; wb_addr = 5'd5; wrdata_sel = 1; mem_out = 32'd7; alu_out = 32'd1;
    instr = mk(0, 1, 16'(5 << 11)); in_valid = 1; rf_b_sel = 0;
    cycle("byp5");
    check("byp5/b_const", 64'(rf_b), 64'd7);

    // Register 0 stays zero, including the same-cycle read
    idle(); wb_wren = 1; wb_addr = 5'd0; alu_out = 32'hFFFF; instr = mk(0, 2, 16'h0); in_valid = 1;
    cycle("wr0");
    idle(); instr = mk(0, 2, 16'h0); in_valid = 1;
    cycle("rd0");
    check("rd0/a_const", 64'(rf_a), 64'd0);

    // Immediate modes
    for (int s = 0; s < 4; s++) begin
      idle(); instr = mk(1, 2, 16'h8001); in_valid = 1; imm_sel = 2'(s);
      cycle($sformatf("imm%0d", s));
      check($sformatf("imm%0d/const", s), 64'(immed), 64'(imm_tab[s]));
    end

    // Load-use: load to r4, then a consumer of r4
    idle(); instr = mk(1, 4, 16'h0); in_valid = 1; is_load = 1;
    cycle("ld4");
    idle(); instr = mk(4, 6, 16'h1234); in_valid = 1;
    #1;
    check("lu/req_const", 64'(load_use_stall), 64'd1);
    cycle("lu_bubble");
    check("lu/bubble_vld", 64'(out_valid), 64'd0);
    check("lu/dst_held", 64'(dst_addr), 64'd4);
    cycle("lu_release");
    check("lu/release_vld", 64'(out_valid), 64'd1);

    // Flush and Stall together: flush wins
    idle(); instr = mk(3, 7, 16'h0042); in_valid = 1;
    cycle("pre_flush");
    flush = 1; stall = 1;
    cycle("flush_stall");
    check("flush_stall/vld_const", 64'(out_valid), 64'd0);

    // Reset in the middle of a stall
    idle(); instr = mk(3, 8, 16'h0077); in_valid = 1;
    cycle("pre_stall");
    stall = 1; instr = mk(5, 9, 16'h0001);
    cycle("stall_hold");
    rst_n = 0;
    #1;
    model_clear();
    check_outputs("async_rst");
    check("async_rst/lus", 64'(load_use_stall), 64'd0);
    @(negedge clk);
    rst_n = 1;
    idle(); instr = mk(3, 1, 16'h0); in_valid = 1;
    cycle("post_rst_rd3");
    check("post_rst/a3_const", 64'(rf_a), 64'd0);

    // Random traffic with a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      instr      = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 11'($urandom)};
      in_valid   = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      imm_sel    = 2'($urandom);
      rf_b_sel   = 1'($urandom);
      is_load    = ($urandom_range(0, 2) == 0);
      wb_wren    = 1'($urandom);
      wb_addr    = 5'($urandom_range(0, 7));
      alu_out    = $urandom;
      mem_out    = $urandom;
      wrdata_sel = 1'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
